session_scheduler: RTL and testbench

SESSION_SCHEDULER -- requirements
Module: session_scheduler

---
 rtl/bitbakery_pkg.sv | 31 +++
 rtl/session_scheduler_if.sv | 31 +++
 rtl/contador_timeout.sv | 26 ++
 rtl/session_scheduler.sv | 122 ++++++++++++
 tb/tb_session_scheduler.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bitbakery_pkg.sv
// Shared definitions for the game-session controller: state codes, game ids,
// score ceiling and a saturating accumulator helper.
package bitbakery_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_SCORE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    GAME_MEMORIA = 2'd0,
    GAME_CAKE    = 2'd1,
    GAME_CLOTHES = 2'd2,
    GAME_INVALID = 2'd3
  } game_e;

  localparam int unsigned TOTAL_MAX              = 511;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

  // Session total clamps at TOTAL_MAX instead of wrapping.
  function automatic logic [8:0] sat_add(input logic [8:0] total, input logic [6:0] score);
    logic [9:0] sum;
    sum = {1'b0, total} + {3'b000, score};
    return (sum > 10'(TOTAL_MAX)) ? 9'(TOTAL_MAX) : sum[8:0];
  endfunction

endpackage

// File: rtl/session_scheduler_if.sv
// Control/score bundle between the session scheduler and its environment.
interface session_scheduler_if;

  logic       iniciar;
  logic       abortar;
  logic       modo;
  logic       dificuldade;
  logic [1:0] minigame;
  logic       pronto_in;
  logic [6:0] pontuacao_in;

  logic       jogar;
  logic [1:0] game_sel;
  logic       dificuldade_out;
  logic [8:0] total;
  logic [6:0] recorde_out;
  logic       timeout;
  logic       fim;
  logic [2:0] estado_out;

  modport master (
    output iniciar, abortar, modo, dificuldade, minigame, pronto_in, pontuacao_in,
    input  jogar, game_sel, dificuldade_out, total, recorde_out, timeout, fim, estado_out
  );

  modport slave (
    input  iniciar, abortar, modo, dificuldade, minigame, pronto_in, pontuacao_in,
    output jogar, game_sel, dificuldade_out, total, recorde_out, timeout, fim, estado_out
  );

endinterface

// File: rtl/contador_timeout.sv
// RUN-state cycle counter; terminal_o flags the last allowed cycle of a game.
module contador_timeout #(
  parameter int unsigned MAX_COUNT = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam int unsigned W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(MAX_COUNT - 1);

  logic [W-1:0] count_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         count_q <= '0;
    else if (clear_i)  count_q <= '0;
    else if (enable_i) count_q <= count_q + W'(1);
  end

  assign terminal_o = (count_q == LAST);

endmodule

// File: rtl/session_scheduler.sv
// Sequences single or marathon game sessions, accumulating a saturating total
// and per-game best scores; abort and timeout end a game without scoring it.
module session_scheduler
  import bitbakery_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  session_scheduler_if.slave  ss
);

  state_e     state_q, state_d;
  logic [1:0] game_sel_q, game_sel_d;
  logic       modo_q, modo_d;
  logic       dif_q, dif_d;
  logic       timeout_q, timeout_d;
  logic [8:0] total_q, total_d;
  logic [6:0] rec_q [4];
  logic [6:0] rec_d [4];
  logic       cnt_clear, cnt_en, cnt_last, start_ok;

  contador_timeout #(.MAX_COUNT(TIMEOUT_CYCLES)) u_contador (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (cnt_clear),
    .enable_i   (cnt_en),
    .terminal_o (cnt_last)
  );

  assign start_ok = ss.iniciar && (ss.modo || (ss.minigame != GAME_INVALID));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    game_sel_d = game_sel_q;
    modo_d     = modo_q;
    dif_d      = dif_q;
    timeout_d  = timeout_q;
    total_d    = total_q;
    rec_d      = rec_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    if (ss.abortar && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      total_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            modo_d     = ss.modo;
            dif_d      = ss.dificuldade;
            game_sel_d = ss.modo ? GAME_MEMORIA : ss.minigame;
            total_d    = '0;
            timeout_d  = 1'b0;
            state_d    = S_START;
          end
        end
        S_START: begin
          cnt_clear = 1'b1;
          state_d   = S_RUN;
        end
        S_RUN: begin
          // A finished game beats an expiry landing in the same cycle.
          if (ss.pronto_in) begin
            timeout_d = 1'b0;
            state_d   = S_SCORE;
          end else if (cnt_last) begin
            timeout_d = 1'b1;
            state_d   = S_SCORE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        S_SCORE: begin
          if (!timeout_q) begin
            total_d = sat_add(total_q, ss.pontuacao_in);
            if (ss.pontuacao_in > rec_q[game_sel_q]) rec_d[game_sel_q] = ss.pontuacao_in;
          end
          state_d = (modo_q && (game_sel_q < 2'd2)) ? S_NEXT : S_DONE;
        end
        S_NEXT: begin
          game_sel_d = game_sel_q + 2'd1;
          state_d    = S_START;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      game_sel_q <= '0;
      modo_q     <= 1'b0;
      dif_q      <= 1'b0;
      timeout_q  <= 1'b0;
      total_q    <= '0;
      // NOTE: the record table is a handful of flops, so it is cleared by reset like any register.
      for (int i = 0; i < 4; i++) rec_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      game_sel_q <= game_sel_d;
      modo_q     <= modo_d;
      dif_q      <= dif_d;
      timeout_q  <= timeout_d;
      total_q    <= total_d;
      rec_q      <= rec_d;
    end
  end

  assign ss.jogar           = (state_q == S_START);
  assign ss.fim             = (state_q == S_DONE);
  assign ss.estado_out      = state_q;
  assign ss.game_sel        = game_sel_q;
  assign ss.dificuldade_out = dif_q;
  assign ss.total           = total_q;
  assign ss.timeout         = timeout_q;
  assign ss.recorde_out     = rec_q[game_sel_q];

endmodule

// File: tb/tb_session_scheduler.sv
// Randomized session-level bench: a per-session score/record model predicts
// totals, records, timeouts and start pulses from game durations and scores.
module tb_session_scheduler;
  import bitbakery_pkg::*;

  localparam int TO = 24;

  logic clock = 1'b0;
  logic reset;

  session_scheduler_if ss();

  session_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .ss    (ss)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int jog_cnt  = 0;
  int m_total;
  int m_rec [3];
  int g_delay [3];
  int g_score [3];

  always @(negedge clock) if (ss.jogar === 1'b1) jog_cnt <= jog_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ss.iniciar = 1'b0; ss.abortar = 1'b0; ss.modo = 1'b0; ss.dificuldade = 1'b0;
    ss.minigame = 2'd0; ss.pronto_in = 1'b0; ss.pontuacao_in = 7'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_estado"}, ss.estado_out, 0);
    check({tag, "_jogar"}, ss.jogar, 0);
    check({tag, "_game_sel"}, ss.game_sel, 0);
    check({tag, "_dif"}, ss.dificuldade_out, 0);
    check({tag, "_total"}, ss.total, 0);
    check({tag, "_recorde"}, ss.recorde_out, 0);
    check({tag, "_timeout"}, ss.timeout, 0);
    check({tag, "_fim"}, ss.fim, 0);
  endtask

  // Invalid single-game request must leave the current state untouched.
  task automatic try_invalid(input int exp_state);
    ss.iniciar = 1'b1; ss.modo = 1'b0; ss.minigame = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("invalid_hold", ss.estado_out, exp_state);
    end
    ss.iniciar = 1'b0;
  endtask

  // One session using g_delay/g_score; optional abort in game ab_game at RUN cycle ab_k.
  task automatic run_session(input bit mode, input int mg, input bit dif,
                             input int ab_game, input int ab_k);
    int n_games, jog0, gs, k, exp_exit;
    bit tmo;
    n_games = mode ? 3 : 1;
    jog0 = jog_cnt;
    ss.iniciar = 1'b1; ss.modo = mode; ss.minigame = 2'(mg); ss.dificuldade = dif;
    tick();
    ss.iniciar = 1'b0;
    m_total = 0;
    check("start_state", ss.estado_out, 1);
    check("start_total", ss.total, 0);
    check("start_timeout", ss.timeout, 0);
    check("dif_out", ss.dificuldade_out, dif);
    gs = mode ? 0 : mg;
    for (int g = 0; g < n_games; g++) begin
      check("jogar_start", ss.jogar, 1);
      check("game_sel", ss.game_sel, gs);
      tick();
      check("run_state", ss.estado_out, 2);
      check("jogar_run", ss.jogar, 0);
      exp_exit = (g_delay[g] < TO) ? g_delay[g] : TO - 1;
      tmo = (g_delay[g] >= TO);
      for (k = 0; k < TO + 8; k++) begin
        ss.pronto_in = (k == g_delay[g]);
        ss.pontuacao_in = 7'(g_score[g]);
        ss.abortar = (g == ab_game) && (k == ab_k);
        tick();
        if (ss.abortar) begin
          ss.abortar = 1'b0; ss.pronto_in = 1'b0;
          check("abort_state", ss.estado_out, 0);
          check("abort_total", ss.total, 0);
          check("abort_jogar", ss.jogar, 0);
          check("abort_recorde", ss.recorde_out, m_rec[gs]);
          check("abort_pulses", jog_cnt - jog0, g + 1);
          return;
        end
        if (ss.estado_out != 3'd2) break;
      end
      ss.pronto_in = 1'b0;
      check("run_len", k, exp_exit);
      check("score_state", ss.estado_out, 3);
      check("timeout_flag", ss.timeout, tmo);
      tick();
      if (!tmo) begin
        m_total = (m_total + g_score[g] > 511) ? 511 : m_total + g_score[g];
        if (g_score[g] > m_rec[gs]) m_rec[gs] = g_score[g];
      end
      check("total", ss.total, m_total);
      check("recorde", ss.recorde_out, m_rec[gs]);
      check("timeout_hold", ss.timeout, tmo);
      if (g < n_games - 1) begin
        check("next_state", ss.estado_out, 4);
        tick();
        gs++;
      end
    end
    check("done_state", ss.estado_out, 5);
    check("fim", ss.fim, 1);
    check("dif_hold", ss.dificuldade_out, dif);
    check("jogar_pulses", jog_cnt - jog0, n_games);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mode, mg, r, ab_game, ab_k;
    idle_inputs();
    for (int i = 0; i < 3; i++) m_rec[i] = 0;
    reset = 1'b1;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    try_invalid(0);

    g_delay[0] = 20; g_score[0] = 45;
    run_session(1'b0, 1, 1'b1, -1, 0);
    check("single_total", ss.total, 45);

    g_delay = '{2, 7, 0}; g_score = '{100, 120, 127};
    run_session(1'b1, 0, 1'b0, -1, 0);
    check("marathon_total", ss.total, 347);

    try_invalid(5);

    g_delay = '{3, 1000, TO - 1}; g_score = '{30, 99, 60};
    run_session(1'b1, 0, 1'b1, -1, 0);
    check("timeout_total", ss.total, 90);

    g_delay[0] = 5; g_score[0] = 126;
    run_session(1'b0, 0, 1'b0, 0, 5);

    for (int s = 0; s < 4; s++) begin
      g_delay = '{1, 4, 2}; g_score = '{127, 127, 127};
      run_session(1'b1, 0, s[0], -1, 0);
      check("sat_total", ss.total, 381);
    end

    for (int s = 0; s < 25; s++) begin
      mode = int'($urandom_range(0, 1));
      mg = int'($urandom_range(0, 2));
      for (int g = 0; g < 3; g++) begin
        r = int'($urandom_range(0, 9));
        g_delay[g] = (r == 0) ? TO - 1 : (r == 1) ? TO + 5 : int'($urandom_range(0, TO - 2));
        g_score[g] = int'($urandom_range(0, 127));
      end
      ab_game = -1; ab_k = 0;
      if ($urandom_range(0, 4) == 0) begin
        ab_game = int'($urandom_range(0, mode ? 2 : 0));
        ab_k = int'($urandom_range(0, 6));
      end
      run_session(mode[0], mg, 1'($urandom_range(0, 1)), ab_game, ab_k);
    end

    // Mid-game asynchronous reset after game 0 has scored.
    ss.iniciar = 1'b1; ss.modo = 1'b1; ss.dificuldade = 1'b1;
    tick();
    ss.iniciar = 1'b0;
    tick();
    ss.pronto_in = 1'b1; ss.pontuacao_in = 7'd50;
    tick();
    ss.pronto_in = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    check("pre_reset_total", ss.total, 50);
    check("pre_reset_state", ss.estado_out, 2);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    for (int i = 0; i < 3; i++) m_rec[i] = 0;
    #2;
    reset = 1'b0;
    tick();

    g_delay[0] = 3; g_score[0] = 9;
    run_session(1'b0, 0, 1'b0, -1, 0);
    check("post_reset_record", ss.recorde_out, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
